// File: rtl/debounce_array.sv
// N-channel push-button conditioner: per-channel synchronizer, saturating-free
// debounce counter, press/release edge pulses and optional auto-repeat.
module debounce_array #(
    parameter int unsigned   N               = 4,
    parameter int unsigned   SYNC_STAGES     = 2,
    parameter int unsigned   DEBOUNCE_CYCLES = 262143,
    parameter logic [N-1:0]  INVERT          = {N{1'b0}},
    parameter int unsigned   REPEAT_EN       = 0,
    parameter int unsigned   REPEAT_DELAY    = 50000000,
    parameter int unsigned   REPEAT_PERIOD   = 10000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] PB,
    output logic [N-1:0] PB_state,
    output logic [N-1:0] PB_down,
    output logic [N-1:0] PB_up,
    output logic [N-1:0] PB_repeat,
    output logic         any_down
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q [N];
    logic [SYNC_STAGES-1:0] sync_d [N];
    logic [CW-1:0]          cnt_q  [N];
    logic [CW-1:0]          cnt_d  [N];
    logic [N-1:0]           s;
    logic [N-1:0]           state_q, state_d;
    logic [N-1:0]           down_q, down_d;
    logic [N-1:0]           up_q, up_d;
    logic [N-1:0]           release_d;
    logic                   any_down_q, any_down_d;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], PB[i]};
            s[i]      = sync_q[i][SYNC_STAGES-1] ^ INVERT[i];
        end
    end

    // Counter only runs while the sample disagrees with the debounced level;
    // any agreement restarts it, so glitches shorter than the window vanish.
    always_comb begin
        state_d   = state_q;
        down_d    = '0;
        up_d      = '0;
        release_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_d[i]     = '0;
                state_d[i]   = ~state_q[i];
                down_d[i]    = ~state_q[i];
                up_d[i]      = state_q[i];
                release_d[i] = state_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        any_down_d = |down_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                sync_q[i] <= {SYNC_STAGES{INVERT[i]}};
                cnt_q[i]  <= '0;
            end
            state_q    <= '0;
            down_q     <= '0;
            up_q       <= '0;
            any_down_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                sync_q[i] <= sync_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            state_q    <= state_d;
            down_q     <= down_d;
            up_q       <= up_d;
            any_down_q <= any_down_d;
        end
    end

    assign PB_state = state_q;
    assign PB_down  = down_q;
    assign PB_up    = up_q;
    assign any_down = any_down_q;

    if (REPEAT_EN != 0) begin : g_repeat
        localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
        localparam int unsigned HW = $clog2(HOLD_MAX + 1);

        typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

        rep_state_e    rs_q   [N];
        rep_state_e    rs_d   [N];
        logic [HW-1:0] hold_q [N];
        logic [HW-1:0] hold_d [N];
        logic [N-1:0]  rep_q, rep_d;

        // hold counts cycles since PB_down (or since the last pulse); the pulse is
        // registered, so it fires when the count is one short of the target.
        always_comb begin
            rep_d = '0;
            for (int unsigned i = 0; i < N; i++) begin
                rs_d[i]   = rs_q[i];
                hold_d[i] = hold_q[i];
                case (rs_q[i])
                    IDLE: begin
                        if (down_q[i]) begin
                            if (REPEAT_DELAY == 1) begin
                                rep_d[i]  = 1'b1;
                                rs_d[i]   = REPEAT;
                                hold_d[i] = '0;
                            end else begin
                                rs_d[i]   = DELAY;
                                hold_d[i] = HW'(1);
                            end
                        end
                    end
                    DELAY: begin
                        if (release_d[i]) begin
                            rs_d[i]   = IDLE;
                            hold_d[i] = '0;
                        end else if (hold_q[i] == HW'(REPEAT_DELAY - 1)) begin
                            rep_d[i]  = 1'b1;
                            rs_d[i]   = REPEAT;
                            hold_d[i] = '0;
                        end else begin
                            hold_d[i] = hold_q[i] + HW'(1);
                        end
                    end
                    REPEAT: begin
                        if (release_d[i]) begin
                            rs_d[i]   = IDLE;
                            hold_d[i] = '0;
                        end else if (hold_q[i] == HW'(REPEAT_PERIOD - 1)) begin
                            rep_d[i]  = 1'b1;
                            hold_d[i] = '0;
                        end else begin
                            hold_d[i] = hold_q[i] + HW'(1);
                        end
                    end
                    default: begin
                        rs_d[i]   = IDLE;
                        hold_d[i] = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < N; i++) begin
                    rs_q[i]   <= IDLE;
                    hold_q[i] <= '0;
                end
                rep_q <= '0;
            end else begin
                for (int unsigned i = 0; i < N; i++) begin
                    rs_q[i]   <= rs_d[i];
                    hold_q[i] <= hold_d[i];
                end
                rep_q <= rep_d;
            end
        end

        assign PB_repeat = rep_q;
    end else begin : g_no_repeat
        assign PB_repeat = '0;
    end

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array with short debounce/repeat windows; a second
// instance covers an active-low channel.
module tb_debounce_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pb, pb2;
    logic [1:0] state, down, up, rep;
    logic [1:0] state2, down2, up2, rep2;
    logic       anyd, anyd2;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    debounce_array #(
        .N(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INVERT(2'b00),
        .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst(rst), .PB(pb), .PB_state(state), .PB_down(down),
        .PB_up(up), .PB_repeat(rep), .any_down(anyd)
    );

    debounce_array #(
        .N(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INVERT(2'b10),
        .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_inv (
        .clk(clk), .rst(rst), .PB(pb2), .PB_state(state2), .PB_down(down2),
        .PB_up(up2), .PB_repeat(rep2), .any_down(anyd2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        pb  = 2'b00;
        pb2 = 2'b10;
        repeat (3) tick;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_down",  32'(down),  32'd0);
        chk("reset_up",    32'(up),    32'd0);
        chk("reset_rep",   32'(rep),   32'd0);
        chk("reset_any",   32'(anyd),  32'd0);
        chk("reset_inv_state", 32'(state2), 32'd0);

        // Press channel 0: state rises on edge 6 with a single down pulse.
        rst = 1'b0;
        pb  = 2'b01;
        for (int e = 1; e <= 6; e++) begin
            tick;
            chk("press_state", 32'(state), (e >= 6) ? 32'd1 : 32'd0);
            chk("press_down",  32'(down),  (e == 6) ? 32'd1 : 32'd0);
            chk("press_any",   32'(anyd),  (e == 6) ? 32'd1 : 32'd0);
        end

        // Hold: repeat at +10 then every 3 cycles after the down pulse.
        for (int k = 1; k <= 30; k++) begin
            tick;
            chk("hold_rep",   32'(rep),   (k >= 10 && (k - 10) % 3 == 0) ? 32'd1 : 32'd0);
            chk("hold_down",  32'(down),  32'd0);
            chk("hold_any",   32'(anyd),  32'd0);
            chk("hold_state", 32'(state), 32'd1);
        end

        // Release: repeats continue until state drops, then stop for good.
        pb = 2'b00;
        for (int i = 1; i <= 12; i++) begin
            tick;
            chk("rel_state", 32'(state), (i >= 6) ? 32'd0 : 32'd1);
            chk("rel_up",    32'(up),    (i == 6) ? 32'd1 : 32'd0);
            chk("rel_rep",   32'(rep),   (i <= 5 && ((30 + i) - 10) % 3 == 0) ? 32'd1 : 32'd0);
        end

        // Three-cycle glitch is one short of the window: rejected.
        pb = 2'b01;
        repeat (3) tick;
        pb = 2'b00;
        for (int i = 1; i <= 12; i++) begin
            tick;
            chk("glitch_state", 32'(state), 32'd0);
            chk("glitch_down",  32'(down),  32'd0);
            chk("glitch_up",    32'(up),    32'd0);
        end

        // Reset with counter at 2 aborts; held button re-debounces afterwards.
        pb = 2'b01;
        repeat (4) tick;
        rst = 1'b1;
        tick;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_down",  32'(down),  32'd0);
        chk("midrst_up",    32'(up),    32'd0);
        chk("midrst_rep",   32'(rep),   32'd0);
        chk("midrst_any",   32'(anyd),  32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick;
            chk("postrst_state", 32'(state), (e >= 6) ? 32'd1 : 32'd0);
            chk("postrst_down",  32'(down),  (e == 6) ? 32'd1 : 32'd0);
        end
        pb = 2'b00;
        for (int i = 1; i <= 7; i++) begin
            tick;
            chk("postrst_up", 32'(up), (i == 6) ? 32'd1 : 32'd0);
        end

        // Active-low channel 1 pressed together with active-high channel 0.
        pb2 = 2'b01;
        for (int e = 1; e <= 7; e++) begin
            tick;
            chk("inv_down",  32'(down2),  (e == 6) ? 32'd3 : 32'd0);
            chk("inv_any",   32'(anyd2),  (e == 6) ? 32'd1 : 32'd0);
            chk("inv_state", 32'(state2), (e >= 6) ? 32'd3 : 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
